// File: rtl/sy_ppl_fpu_rob_if.sv
// sy_ppl_fpu_rob_if: opcode/fu types and the decode/csr/core/retire bus of the FPU ROB (slave = ROB side, master = environment)
package sy_ppl_fpu_rob_pkg;
  typedef enum logic [4:0] {
    FADD, FSUB, FMUL, FDIV, FSQRT, FMADD, FMSUB, FNMADD, FNMSUB, FSGNJ,
    FMIN_MAX, FCMP, FCLASS, FMV_X2F, FMV_F2X, FCVT_F2F, FCVT_F2I, FCVT_I2F
  } fpu_opcode_t;
  typedef enum logic [2:0] {FU_NONE, FU_ALU, FU_LSU, FU_MUL, FU_FPU} fu_t;
endpackage

interface sy_ppl_fpu_rob_if #(parameter int DWTH = 64, parameter int FLEN = 64, parameter int DEPTH = 4);
  import sy_ppl_fpu_rob_pkg::*;
  localparam int TAG_W = $clog2(DEPTH);
  typedef struct packed {
    fu_t fu;
    fpu_opcode_t operation;
    logic [DWTH-1:0] operand_a;
    logic [DWTH-1:0] operand_b;
    logic [DWTH-1:0] imm;
    logic [TAG_W-1:0] trans_id;
  } fu_data_t;
  logic flush_i;
  logic dec_fpu__valid_i;
  logic fpu_dec__ready_o;
  fpu_opcode_t dec_fpu__opcode_i;
  logic [DWTH-1:0] dec_fpu__rs1_data_i;
  logic [DWTH-1:0] dec_fpu__rs2_data_i;
  logic [DWTH-1:0] dec_fpu__rs3_data_i;
  logic [1:0] dec_fpu__fmt_i;
  logic [2:0] dec_fpu__rm_i;
  logic [2:0] csr_fpu__frm_i;
  logic [6:0] csr_fpu__prec_i;
  logic csr_fpu__fflags_clr_i;
  logic fpu_core__valid_o;
  logic core_fpu__ready_i;
  fu_data_t fpu_core__data_o;
  logic [2:0] fpu_core__rm_o;
  logic [1:0] fpu_core__fmt_o;
  logic [6:0] fpu_core__prec_o;
  logic core_fpu__valid_i;
  logic [TAG_W-1:0] core_fpu__trans_id_i;
  logic [FLEN-1:0] core_fpu__result_i;
  logic [4:0] core_fpu__status_i;
  logic fpu_dec__valid_o;
  logic dec_fpu__ready_i;
  logic [FLEN-1:0] fpu_dec__result_o;
  logic [4:0] fpu_dec__status_o;
  logic [4:0] fpu_dec__fflags_o;
  modport slave (
    input flush_i, dec_fpu__valid_i, dec_fpu__opcode_i, dec_fpu__rs1_data_i, dec_fpu__rs2_data_i,
          dec_fpu__rs3_data_i, dec_fpu__fmt_i, dec_fpu__rm_i, csr_fpu__frm_i, csr_fpu__prec_i,
          csr_fpu__fflags_clr_i, core_fpu__ready_i, core_fpu__valid_i, core_fpu__trans_id_i,
          core_fpu__result_i, core_fpu__status_i, dec_fpu__ready_i,
    output fpu_dec__ready_o, fpu_core__valid_o, fpu_core__data_o, fpu_core__rm_o, fpu_core__fmt_o,
           fpu_core__prec_o, fpu_dec__valid_o, fpu_dec__result_o, fpu_dec__status_o, fpu_dec__fflags_o
  );
  modport master (
    output flush_i, dec_fpu__valid_i, dec_fpu__opcode_i, dec_fpu__rs1_data_i, dec_fpu__rs2_data_i,
           dec_fpu__rs3_data_i, dec_fpu__fmt_i, dec_fpu__rm_i, csr_fpu__frm_i, csr_fpu__prec_i,
           csr_fpu__fflags_clr_i, core_fpu__ready_i, core_fpu__valid_i, core_fpu__trans_id_i,
           core_fpu__result_i, core_fpu__status_i, dec_fpu__ready_i,
    input fpu_dec__ready_o, fpu_core__valid_o, fpu_core__data_o, fpu_core__rm_o, fpu_core__fmt_o,
          fpu_core__prec_o, fpu_dec__valid_o, fpu_dec__result_o, fpu_dec__status_o, fpu_dec__fflags_o
  );
endinterface

// File: rtl/sy_ppl_fpu_rob.sv
// sy_ppl_fpu_rob: FPU issue/in-order-retire ROB; ports clk_i, rst_i, bus (decode issue, csr, core issue/complete, decode retire, fflags)
module sy_ppl_fpu_rob #(parameter int DWTH = 64, parameter int FLEN = 64, parameter int DEPTH = 4) (
  input logic clk_i,
  input logic rst_i,
  sy_ppl_fpu_rob_if.slave bus
);
  import sy_ppl_fpu_rob_pkg::*;
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CW = TAG_W + 1;
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d, core_q, core_d, hmask;
  logic [FLEN-1:0] res_q [DEPTH];
  logic [FLEN-1:0] res_d [DEPTH];
  logic [4:0] sts_q [DEPTH];
  logic [4:0] sts_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, nidx, tid;
  logic [CW-1:0] cnt_q, cnt_d, pend_q, pend_d;
  logic out_v_q, out_v_d;
  logic [FLEN-1:0] out_r_q, out_r_d;
  logic [4:0] out_s_q, out_s_d, ff_q, ff_d;
  logic [2:0] rm;
  logic illegal, open, rdy, cv, accept, take, load, hit;
  logic [DWTH-1:0] a, b, imm;
  always_comb begin
    rm = bus.dec_fpu__rm_i == 3'b111 ? bus.csr_fpu__frm_i : bus.dec_fpu__rm_i;
    illegal = rm >= 3'd5;
    open = cnt_q != CW'(DEPTH) & pend_q == '0 & !bus.flush_i;
    rdy = open & (bus.core_fpu__ready_i | illegal);
    cv = bus.dec_fpu__valid_i & open & !illegal;
    accept = bus.dec_fpu__valid_i & rdy;
    take = out_v_q & bus.dec_fpu__ready_i;
    a = bus.dec_fpu__rs1_data_i;
    b = bus.dec_fpu__rs2_data_i;
    imm = bus.dec_fpu__rs3_data_i;
    case (bus.dec_fpu__opcode_i)
      FADD: begin a = '0; b = bus.dec_fpu__rs1_data_i; imm = bus.dec_fpu__rs2_data_i; end
      FSUB, FMV_X2F, FMV_F2X, FCLASS: begin b = bus.dec_fpu__rs1_data_i; imm = bus.dec_fpu__rs2_data_i; end
      FSQRT: b = '0;
      FCVT_F2F, FCVT_F2I, FCVT_I2F: b = bus.dec_fpu__rs1_data_i;
      default: ;
    endcase
    bus.fpu_dec__ready_o = rdy;
    bus.fpu_core__valid_o = cv;
    bus.fpu_core__data_o = '0;
    if (cv) begin
      bus.fpu_core__data_o.fu = FU_FPU;
      bus.fpu_core__data_o.operation = bus.dec_fpu__opcode_i;
      bus.fpu_core__data_o.operand_a = a;
      bus.fpu_core__data_o.operand_b = b;
      bus.fpu_core__data_o.imm = imm;
      bus.fpu_core__data_o.trans_id = tail_q;
    end
    bus.fpu_core__rm_o = cv ? rm : '0;
    bus.fpu_core__fmt_o = cv ? bus.dec_fpu__fmt_i : '0;
    bus.fpu_core__prec_o = cv ? bus.csr_fpu__prec_i : '0;
    bus.fpu_dec__valid_o = out_v_q;
    bus.fpu_dec__result_o = out_r_q;
    bus.fpu_dec__status_o = out_s_q;
    bus.fpu_dec__fflags_o = ff_q;
  end
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    core_d = core_q;
    res_d = res_q;
    sts_d = sts_q;
    head_d = head_q;
    tail_d = tail_q;
    pend_d = pend_q;
    out_v_d = out_v_q;
    out_r_d = out_r_q;
    out_s_d = out_s_q;
    tid = bus.core_fpu__trans_id_i;
    hit = bus.core_fpu__valid_i & busy_q[tid];
    hmask = DEPTH'(hit) << tid;
    if (bus.core_fpu__valid_i & !busy_q[tid] & pend_q != '0) pend_d = pend_q - CW'(1);
    if (hit) begin
      res_d[tid] = bus.core_fpu__result_i;
      sts_d[tid] = bus.core_fpu__status_i;
      done_d[tid] = 1'b1;
    end
    if (accept) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = illegal;
      core_d[tail_q] = !illegal;
      res_d[tail_q] = '0;
      sts_d[tail_q] = illegal ? 5'b10000 : 5'b0;
      tail_d = tail_q + TAG_W'(1);
    end
    nidx = take ? head_q + TAG_W'(1) : head_q;
    load = busy_q[nidx] & done_q[nidx] & (!out_v_q | take);
    if (take) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      core_d[head_q] = 1'b0;
      head_d = head_q + TAG_W'(1);
      out_v_d = 1'b0;
    end
    if (load) begin
      out_v_d = 1'b1;
      out_r_d = res_q[nidx];
      out_s_d = sts_q[nidx];
    end
    cnt_d = cnt_q + CW'(accept) - CW'(take);
    ff_d = (bus.csr_fpu__fflags_clr_i ? 5'b0 : ff_q) | (take ? out_s_q : 5'b0);
    if (bus.flush_i) begin
      pend_d = pend_d + CW'($countones(busy_q & core_q & ~done_q & ~hmask));
      busy_d = '0;
      done_d = '0;
      core_d = '0;
      head_d = tail_q;
      cnt_d = '0;
      out_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      done_q <= '0;
      core_q <= '0;
      res_q <= '{default: '0};
      sts_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      out_v_q <= 1'b0;
      out_r_q <= '0;
      out_s_q <= '0;
      ff_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      core_q <= core_d;
      res_q <= res_d;
      sts_q <= sts_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      out_v_q <= out_v_d;
      out_r_q <= out_r_d;
      out_s_q <= out_s_d;
      ff_q <= ff_d;
    end
  end
endmodule

// File: tb/tb_sy_ppl_fpu_rob.sv
// tb_sy_ppl_fpu_rob: table, directed and randomized model-checked bench for sy_ppl_fpu_rob
module tb_sy_ppl_fpu_rob;
  import sy_ppl_fpu_rob_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam logic [63:0] A = 64'h0123456789abcdef;
  localparam logic [63:0] B = 64'hfedcba9876543210;
  localparam logic [63:0] C = 64'h0f0f0f0f0f0f0f0f;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sy_ppl_fpu_rob_if #(.DWTH(64), .FLEN(64), .DEPTH(DEPTH)) bus ();
  sy_ppl_fpu_rob #(.DWTH(64), .FLEN(64), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  typedef struct {
    fpu_opcode_t op;
    logic [2:0] rm;
    logic [2:0] frm;
    logic v;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] imm;
    logic [2:0] erm;
  } vec_t;
  typedef struct { logic [63:0] r; logic [4:0] s; } res_t;
  typedef struct { logic [TAG_W-1:0] t; logic [63:0] r; logic [4:0] s; } cmp_t;
  vec_t vt [10];
  res_t expq [$];
  cmp_t coreq [$];
  int outst = 0;
  int nacc = 0;
  logic [4:0] ffm = 5'b0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.flush_i = 0;
    bus.dec_fpu__valid_i = 0;
    bus.dec_fpu__opcode_i = FMUL;
    bus.dec_fpu__rs1_data_i = A;
    bus.dec_fpu__rs2_data_i = B;
    bus.dec_fpu__rs3_data_i = C;
    bus.dec_fpu__fmt_i = 2'd1;
    bus.dec_fpu__rm_i = 3'd0;
    bus.csr_fpu__frm_i = 3'd0;
    bus.csr_fpu__prec_i = 7'd0;
    bus.csr_fpu__fflags_clr_i = 0;
    bus.core_fpu__ready_i = 1;
    bus.core_fpu__valid_i = 0;
    bus.core_fpu__trans_id_i = '0;
    bus.core_fpu__result_i = '0;
    bus.core_fpu__status_i = '0;
    bus.dec_fpu__ready_i = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    idle();
    step();
    step();
    rst = 0;
  endtask
  task automatic complete(input logic [TAG_W-1:0] t, input logic [63:0] r, input logic [4:0] s);
    bus.core_fpu__valid_i = 1;
    bus.core_fpu__trans_id_i = t;
    bus.core_fpu__result_i = r;
    bus.core_fpu__status_i = s;
    step();
    bus.core_fpu__valid_i = 0;
  endtask
  task automatic wait_valid(input int lim, input string n);
    int i = 0;
    while (!bus.fpu_dec__valid_o && i < lim) begin
      step();
      i++;
    end
    chk(n, 64'(bus.fpu_dec__valid_o), 64'd1);
  endtask
  task automatic rnd_cycle(input bit issue);
    logic [2:0] rrm;
    logic ill, er, tk;
    logic [63:0] r;
    logic [4:0] s;
    int k;
    step();
    chk("rnd_fflags", 64'(bus.fpu_dec__fflags_o), 64'(ffm));
    bus.dec_fpu__valid_i = issue ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.dec_fpu__opcode_i = fpu_opcode_t'($urandom_range(0, 17));
    bus.dec_fpu__rs1_data_i = {$urandom, $urandom};
    bus.dec_fpu__rs2_data_i = {$urandom, $urandom};
    bus.dec_fpu__rs3_data_i = {$urandom, $urandom};
    bus.dec_fpu__rm_i = 3'($urandom_range(0, 7));
    bus.csr_fpu__frm_i = 3'($urandom_range(0, 7));
    bus.core_fpu__ready_i = $urandom_range(0, 3) != 0;
    bus.dec_fpu__ready_i = $urandom_range(0, 2) != 0;
    bus.csr_fpu__fflags_clr_i = $urandom_range(0, 15) == 0;
    bus.core_fpu__valid_i = 0;
    if (coreq.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, coreq.size() - 1);
      bus.core_fpu__valid_i = 1;
      bus.core_fpu__trans_id_i = coreq[k].t;
      bus.core_fpu__result_i = coreq[k].r;
      bus.core_fpu__status_i = coreq[k].s;
      coreq.delete(k);
    end
    #1;
    rrm = bus.dec_fpu__rm_i == 3'b111 ? bus.csr_fpu__frm_i : bus.dec_fpu__rm_i;
    ill = rrm >= 3'd5;
    er = outst < DEPTH && (bus.core_fpu__ready_i || ill);
    chk("rnd_ready", 64'(bus.fpu_dec__ready_o), 64'(er));
    chk("rnd_cvalid", 64'(bus.fpu_core__valid_o), 64'(bus.dec_fpu__valid_i && outst < DEPTH && !ill));
    if (bus.dec_fpu__valid_i && er) begin
      r = {$urandom, $urandom};
      s = 5'($urandom_range(0, 31));
      if (ill) expq.push_back('{64'd0, 5'h10});
      else begin
        chk("rnd_tag", 64'(bus.fpu_core__data_o.trans_id), 64'(nacc % DEPTH));
        chk("rnd_rm", 64'(bus.fpu_core__rm_o), 64'(rrm));
        expq.push_back('{r, s});
        coreq.push_back('{TAG_W'(nacc % DEPTH), r, s});
      end
      nacc++;
      outst++;
    end
    tk = 0;
    s = 5'b0;
    if (bus.fpu_dec__valid_o) begin
      chk("rnd_spurious", 64'(expq.size() != 0), 64'd1);
      if (bus.dec_fpu__ready_i && expq.size() != 0) begin
        chk("rnd_result", bus.fpu_dec__result_o, expq[0].r);
        chk("rnd_status", 64'(bus.fpu_dec__status_o), 64'(expq[0].s));
        s = expq[0].s;
        tk = 1;
        void'(expq.pop_front());
        outst--;
      end
    end
    ffm = (bus.csr_fpu__fflags_clr_i ? 5'b0 : ffm) | (tk ? s : 5'b0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  initial begin
    vt[0] = '{FADD, 3'd0, 3'd0, 1'b1, 64'd0, A, B, 3'd0};
    vt[1] = '{FSUB, 3'd1, 3'd0, 1'b1, A, A, B, 3'd1};
    vt[2] = '{FMUL, 3'd2, 3'd0, 1'b1, A, B, C, 3'd2};
    vt[3] = '{FSQRT, 3'd7, 3'd3, 1'b1, A, 64'd0, C, 3'd3};
    vt[4] = '{FMV_F2X, 3'd4, 3'd0, 1'b1, A, A, B, 3'd4};
    vt[5] = '{FCLASS, 3'd0, 3'd0, 1'b1, A, A, B, 3'd0};
    vt[6] = '{FCVT_I2F, 3'd7, 3'd4, 1'b1, A, A, C, 3'd4};
    vt[7] = '{FMADD, 3'd7, 3'd5, 1'b0, 64'd0, 64'd0, 64'd0, 3'd0};
    vt[8] = '{FDIV, 3'd6, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 3'd0};
    vt[9] = '{FCVT_F2F, 3'd3, 3'd0, 1'b1, A, A, C, 3'd3};
    idle();
    do_reset();
    chk("rst_valid", 64'(bus.fpu_dec__valid_o), 64'd0);
    chk("rst_result", bus.fpu_dec__result_o, 64'd0);
    chk("rst_status", 64'(bus.fpu_dec__status_o), 64'd0);
    chk("rst_fflags", 64'(bus.fpu_dec__fflags_o), 64'd0);
    chk("rst_cvalid", 64'(bus.fpu_core__valid_o), 64'd0);
    bus.core_fpu__ready_i = 0;
    for (int i = 0; i < 10; i++) begin
      bus.dec_fpu__valid_i = 1;
      bus.dec_fpu__opcode_i = vt[i].op;
      bus.dec_fpu__rm_i = vt[i].rm;
      bus.csr_fpu__frm_i = vt[i].frm;
      #1;
      chk($sformatf("tbl%0d_cvalid", i), 64'(bus.fpu_core__valid_o), 64'(vt[i].v));
      chk($sformatf("tbl%0d_ready", i), 64'(bus.fpu_dec__ready_o), 64'(!vt[i].v));
      if (vt[i].v) begin
        chk($sformatf("tbl%0d_a", i), bus.fpu_core__data_o.operand_a, vt[i].a);
        chk($sformatf("tbl%0d_b", i), bus.fpu_core__data_o.operand_b, vt[i].b);
        chk($sformatf("tbl%0d_imm", i), bus.fpu_core__data_o.imm, vt[i].imm);
        chk($sformatf("tbl%0d_rm", i), 64'(bus.fpu_core__rm_o), 64'(vt[i].erm));
        chk($sformatf("tbl%0d_fu", i), 64'(bus.fpu_core__data_o.fu), 64'(FU_FPU));
        chk($sformatf("tbl%0d_op", i), 64'(bus.fpu_core__data_o.operation), 64'(vt[i].op));
      end
      step();
    end
    do_reset();
    bus.dec_fpu__valid_i = 1;
    bus.dec_fpu__opcode_i = FADD;
    bus.dec_fpu__rs1_data_i = 64'h3FF0000000000000;
    bus.dec_fpu__rs2_data_i = 64'h4000000000000000;
    #1;
    chk("fadd_cvalid", 64'(bus.fpu_core__valid_o), 64'd1);
    chk("fadd_a", bus.fpu_core__data_o.operand_a, 64'd0);
    chk("fadd_b", bus.fpu_core__data_o.operand_b, 64'h3FF0000000000000);
    chk("fadd_imm", bus.fpu_core__data_o.imm, 64'h4000000000000000);
    chk("fadd_tag", 64'(bus.fpu_core__data_o.trans_id), 64'd0);
    step();
    bus.dec_fpu__valid_i = 0;
    complete(2'd0, 64'h4008000000000000, 5'd0);
    chk("lat_n1", 64'(bus.fpu_dec__valid_o), 64'd0);
    step();
    chk("lat_n2", 64'(bus.fpu_dec__valid_o), 64'd1);
    chk("fadd_result", bus.fpu_dec__result_o, 64'h4008000000000000);
    chk("fadd_status", 64'(bus.fpu_dec__status_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 64'(bus.fpu_dec__valid_o), 64'd1);
      chk("hold_result", bus.fpu_dec__result_o, 64'h4008000000000000);
      chk("hold_status", 64'(bus.fpu_dec__status_o), 64'd0);
    end
    bus.dec_fpu__ready_i = 1;
    step();
    bus.dec_fpu__ready_i = 0;
    chk("fadd_taken", 64'(bus.fpu_dec__valid_o), 64'd0);
    chk("fadd_fflags", 64'(bus.fpu_dec__fflags_o), 64'd0);
    do_reset();
    bus.dec_fpu__valid_i = 1;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk($sformatf("ord_tag%0d", t), 64'(bus.fpu_core__data_o.trans_id), 64'(t));
      step();
    end
    bus.dec_fpu__valid_i = 0;
    complete(2'd2, 64'hCCCC, 5'd1);
    complete(2'd0, 64'hAAAA, 5'd2);
    complete(2'd1, 64'hBBBB, 5'd4);
    bus.dec_fpu__ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(8, "ord_valid");
      chk($sformatf("ord_result%0d", k), bus.fpu_dec__result_o, 64'hAAAA + 64'(k) * 64'h1111);
      step();
    end
    bus.dec_fpu__ready_i = 0;
    chk("ord_fflags", 64'(bus.fpu_dec__fflags_o), 64'h7);
    do_reset();
    bus.dec_fpu__valid_i = 1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("full_ready", 64'(bus.fpu_dec__ready_o), 64'd0);
    complete(2'd0, 64'h1234, 5'd0);
    wait_valid(8, "full_valid");
    chk("full_hold_ready", 64'(bus.fpu_dec__ready_o), 64'd0);
    bus.dec_fpu__ready_i = 1;
    chk("full_take_ready", 64'(bus.fpu_dec__ready_o), 64'd0);
    step();
    bus.dec_fpu__ready_i = 0;
    chk("full_after_ready", 64'(bus.fpu_dec__ready_o), 64'd1);
    bus.dec_fpu__valid_i = 0;
    do_reset();
    bus.core_fpu__ready_i = 0;
    bus.dec_fpu__valid_i = 1;
    bus.dec_fpu__rm_i = 3'b111;
    bus.csr_fpu__frm_i = 3'b101;
    #1;
    chk("ill_ready", 64'(bus.fpu_dec__ready_o), 64'd1);
    chk("ill_cvalid", 64'(bus.fpu_core__valid_o), 64'd0);
    step();
    bus.dec_fpu__valid_i = 0;
    bus.dec_fpu__rm_i = 3'd0;
    bus.core_fpu__ready_i = 1;
    chk("ill_v1", 64'(bus.fpu_dec__valid_o), 64'd0);
    step();
    chk("ill_v2", 64'(bus.fpu_dec__valid_o), 64'd1);
    chk("ill_result", bus.fpu_dec__result_o, 64'd0);
    chk("ill_status", 64'(bus.fpu_dec__status_o), 64'h10);
    bus.dec_fpu__ready_i = 1;
    step();
    bus.dec_fpu__ready_i = 0;
    chk("ill_fflags", 64'(bus.fpu_dec__fflags_o), 64'h10);
    bus.dec_fpu__valid_i = 1;
    step();
    step();
    bus.dec_fpu__valid_i = 0;
    bus.flush_i = 1;
    #1;
    chk("fl_ready_flush", 64'(bus.fpu_dec__ready_o), 64'd0);
    step();
    bus.flush_i = 0;
    bus.dec_fpu__valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      chk("fl_drain_ready", 64'(bus.fpu_dec__ready_o), 64'd0);
      chk("fl_drain_cvalid", 64'(bus.fpu_core__valid_o), 64'd0);
      chk("fl_drain_dvalid", 64'(bus.fpu_dec__valid_o), 64'd0);
      step();
    end
    complete(2'd1, 64'h55, 5'd3);
    chk("fl_one_left", 64'(bus.fpu_dec__ready_o), 64'd0);
    complete(2'd2, 64'h66, 5'd3);
    chk("fl_drained", 64'(bus.fpu_dec__ready_o), 64'd1);
    bus.dec_fpu__valid_i = 0;
    chk("fl_no_dvalid", 64'(bus.fpu_dec__valid_o), 64'd0);
    chk("fl_fflags", 64'(bus.fpu_dec__fflags_o), 64'h10);
    do_reset();
    bus.dec_fpu__valid_i = 1;
    step();
    bus.dec_fpu__valid_i = 0;
    rst = 1;
    step();
    rst = 0;
    complete(2'd0, 64'h77, 5'd1);
    step();
    step();
    chk("rstmid_dvalid", 64'(bus.fpu_dec__valid_o), 64'd0);
    chk("rstmid_ready", 64'(bus.fpu_dec__ready_o), 64'd1);
    do_reset();
    for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 400 && expq.size() > 0; i++) rnd_cycle(1'b0);
    chk("rnd_drain", 64'(expq.size()), 64'd0);
    step();
    chk("rnd_fflags_end", 64'(bus.fpu_dec__fflags_o), 64'(ffm));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
